// File: rtl/i2cmb_wb_sequencer.sv
// Wishbone master that drives the IICMB controller through one single-byte I2C transfer per request:
// enable, set bus, start, address, data or read-with-NAK, stop. It decodes the CMDR status after each command.
module i2cmb_wb_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int NUM_I2C_BUSSES = 1,
  parameter int IRQ_TIMEOUT    = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_rw_i,
  input  logic [3:0]               req_bus_i,
  input  logic [6:0]               req_addr_i,
  input  logic [7:0]               req_data_i,
  output logic                     rsp_valid_o,
  output logic [7:0]               rsp_data_o,
  output logic [1:0]               rsp_status_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  input  logic                     irq_i
);
  localparam int CW = $clog2(IRQ_TIMEOUT + 1);
  localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);

  typedef enum logic [4:0] {
    IDLE, ENABLE, CHKBUS, SETBUS_D, SETBUS_C, START_C, ADDR_D, ADDR_C,
    DATA_D, DATA_C, RDNAK_C, RD_DPR, STOP_C, WAIT, WAIT_RD, TO_CSR, RESP
  } state_t;

  state_t state_q, state_d, ret_q, ret_d;
  logic rw_q, rw_d, en_q, en_d, rdy_q;
  logic [3:0] bus_q, bus_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdat_q, wdat_d, rdat_q, rdat_d;
  logic [1:0] st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cyc_q, cyc_d, we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d, acc_adr;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d, acc_dat;
  logic acc_req, acc_we, acc_done;
  logic [7:0] rd8;

  assign acc_done = cyc_q & ack_i;
  assign rd8      = dat_i[7:0];

  function automatic logic [7:0] cmd_code(input state_t s);
    case (s)
      SETBUS_C: return 8'h06;
      START_C:  return 8'h04;
      RDNAK_C:  return 8'h03;
      STOP_C:   return 8'h05;
      default:  return 8'h01;
    endcase
  endfunction

  // The first non-OK status sticks; later failures (e.g. during STOP) do not overwrite it.
  function automatic logic [1:0] first_err(input logic [1:0] cur, input logic [1:0] code);
    return (cur == 2'b00) ? code : cur;
  endfunction

  always_comb begin
    state_d = state_q; ret_d = ret_q; rw_d = rw_q; en_d = en_q;
    bus_d = bus_q; addr_d = addr_q; wdat_d = wdat_q; rdat_d = rdat_q;
    st_d = st_q; cnt_d = cnt_q;
    cyc_d = cyc_q; we_d = we_q; adr_d = adr_q; dat_d = dat_q;
    acc_req = 1'b0; acc_we = 1'b1; acc_adr = A_CSR; acc_dat = '0;
    case (state_q)
      IDLE: if (req_valid_i && rdy_q) begin
        rw_d = req_rw_i; bus_d = req_bus_i; addr_d = req_addr_i; wdat_d = req_data_i;
        st_d = 2'b00; rdat_d = 8'h00;
        state_d = en_q ? CHKBUS : ENABLE;
      end
      ENABLE: begin
        acc_req = 1'b1; acc_adr = A_CSR; acc_dat = WB_DATA_WIDTH'(8'hC0);
        if (acc_done) begin en_d = 1'b1; state_d = CHKBUS; end
      end
      CHKBUS: begin
        if (int'(bus_q) >= NUM_I2C_BUSSES) begin st_d = 2'b11; state_d = RESP; end
        else state_d = SETBUS_D;
      end
      SETBUS_D: begin
        acc_req = 1'b1; acc_adr = A_DPR; acc_dat = WB_DATA_WIDTH'({4'b0, bus_q});
        if (acc_done) state_d = SETBUS_C;
      end
      ADDR_D: begin
        acc_req = 1'b1; acc_adr = A_DPR; acc_dat = WB_DATA_WIDTH'({addr_q, rw_q});
        if (acc_done) state_d = ADDR_C;
      end
      DATA_D: begin
        acc_req = 1'b1; acc_adr = A_DPR; acc_dat = WB_DATA_WIDTH'(wdat_q);
        if (acc_done) state_d = DATA_C;
      end
      SETBUS_C, START_C, ADDR_C, DATA_C, RDNAK_C, STOP_C: begin
        acc_req = 1'b1; acc_adr = A_CMDR; acc_dat = WB_DATA_WIDTH'(cmd_code(state_q));
        if (acc_done) begin ret_d = state_q; cnt_d = '0; state_d = WAIT; end
      end
      WAIT: begin
        if (irq_i) state_d = WAIT_RD;
        else if (cnt_q == CW'(IRQ_TIMEOUT - 1)) begin
          st_d = first_err(st_q, 2'b11); state_d = TO_CSR;
        end else cnt_d = cnt_q + 1'b1;
      end
      WAIT_RD: begin
        acc_req = 1'b1; acc_we = 1'b0; acc_adr = A_CMDR;
        if (acc_done) begin
          if (rd8[7]) begin
            case (ret_q)
              SETBUS_C: state_d = START_C;
              START_C:  state_d = ADDR_D;
              ADDR_C:   state_d = rw_q ? RDNAK_C : DATA_D;
              DATA_C:   state_d = STOP_C;
              RDNAK_C:  state_d = RD_DPR;
              default:  state_d = RESP;
            endcase
          end else if (rd8[6] && (ret_q == ADDR_C || ret_q == DATA_C)) begin
            st_d = first_err(st_q, 2'b01); state_d = STOP_C;
          end else if (rd8[5]) begin
            st_d = first_err(st_q, 2'b10); state_d = RESP;
          end else begin
            // ERR or an unexpected status; a failing STOP must not loop back into STOP
            st_d = first_err(st_q, 2'b11);
            state_d = (ret_q == STOP_C) ? RESP : STOP_C;
          end
        end
      end
      RD_DPR: begin
        acc_req = 1'b1; acc_we = 1'b0; acc_adr = A_DPR;
        if (acc_done) begin rdat_d = rd8; state_d = STOP_C; end
      end
      TO_CSR: begin
        acc_req = 1'b1; acc_adr = A_CSR; acc_dat = '0;
        if (acc_done) begin en_d = 1'b0; state_d = RESP; end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Launch only from an idle bus, so the cycle after each ack is always idle.
    if (acc_req && !cyc_q) begin cyc_d = 1'b1; we_d = acc_we; adr_d = acc_adr; dat_d = acc_dat; end
    if (acc_done) cyc_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE; ret_q <= IDLE; rw_q <= 1'b0; en_q <= 1'b0; rdy_q <= 1'b0;
      bus_q <= '0; addr_q <= '0; wdat_q <= '0; rdat_q <= '0; st_q <= '0; cnt_q <= '0;
      cyc_q <= 1'b0; we_q <= 1'b0; adr_q <= '0; dat_q <= '0;
    end else begin
      state_q <= state_d; ret_q <= ret_d; rw_q <= rw_d; en_q <= en_d;
      rdy_q <= (state_d == IDLE);
      bus_q <= bus_d; addr_q <= addr_d; wdat_q <= wdat_d; rdat_q <= rdat_d;
      st_q <= st_d; cnt_q <= cnt_d;
      cyc_q <= cyc_d; we_q <= we_d; adr_q <= adr_d; dat_q <= dat_d;
    end
  end

  assign req_ready_o  = rdy_q;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_data_o   = rdat_q;
  assign rsp_status_o = st_q;
  assign cyc_o        = cyc_q;
  assign stb_o        = cyc_q;
  assign we_o         = we_q;
  assign adr_o        = adr_q;
  assign dat_o        = dat_q;
endmodule
